// File: rtl/ldiv_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ldiv_rr_arbiter
//
// Round-robin front end that shares one pipelined long divider between
// N_REQ requesters. The divider has a fixed latency, accepts one op per
// cycle and never stalls. This block:
//   - grants at most one requester per cycle (round-robin from pointer),
//   - registers the granted operands onto the divider input bus,
//   - carries a {valid, id, dbz} tag alongside every op in a shift register
//     aligned to the divider latency,
//   - routes the divider result (or a locally generated divide-by-zero
//     result) back to the issuing requester as a one-cycle pulse.
//
// Optional build macro: LDIV_RR_ARBITER_SYNC_CHECK_EN
//   When defined, div_valid_out is compared every cycle with the tag
//   pipeline; a disagreement sets the sticky sync_err and suppresses the
//   response for that cycle. When undefined, sync_err is tied to 0.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req_valid[N]        per-requester request valid
//   req_ready[N]        one-hot grant (combinational)
//   req_numerator       flattened, requester i at [i*NW +: NW]
//   req_denominator     flattened, requester i at [i*DW +: DW]
//   div_numerator       registered operand to divider
//   div_denominator     registered operand to divider
//   div_valid           registered divider valid_in
//   div_quotient        divider result
//   div_remainder       divider result
//   div_valid_out       divider result valid
//   rsp_valid[N]        one-hot response pulse (no backpressure)
//   rsp_quotient        shared response data
//   rsp_remainder       shared response data
//   rsp_dbz             response was a divide-by-zero
//   sync_err            sticky divider/tag disagreement flag
//
// Handshake: a request transfers on a rising clk edge where req_valid[i]
// and req_ready[i] are both 1. req_valid must not depend on req_ready;
// once asserted, it may be held until the grant arrives. Responses use
// valid only: rsp_valid pulses for exactly one cycle and cannot be
// stalled, so the requester must take the data in that cycle.
// ---------------------------------------------------------------------------
module ldiv_rr_arbiter #(
  parameter int N_REQ             = 4,
  parameter int NUMERATOR_WIDTH   = 24,
  parameter int DENOMINATOR_WIDTH = 20,
  parameter int QUOTIENT_WIDTH    = 24,
  parameter int DIV_LATENCY       = 24
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [N_REQ-1:0]                       req_valid,
  output logic [N_REQ-1:0]                       req_ready,
  input  logic [N_REQ*NUMERATOR_WIDTH-1:0]       req_numerator,
  input  logic [N_REQ*DENOMINATOR_WIDTH-1:0]     req_denominator,
  output logic [NUMERATOR_WIDTH-1:0]             div_numerator,
  output logic [DENOMINATOR_WIDTH-1:0]           div_denominator,
  output logic                                   div_valid,
  input  logic [QUOTIENT_WIDTH-1:0]              div_quotient,
  input  logic [NUMERATOR_WIDTH-1:0]             div_remainder,
  input  logic                                   div_valid_out,
  output logic [N_REQ-1:0]                       rsp_valid,
  output logic [QUOTIENT_WIDTH-1:0]              rsp_quotient,
  output logic [NUMERATOR_WIDTH-1:0]             rsp_remainder,
  output logic                                   rsp_dbz,
  output logic                                   sync_err
);

  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // One stage per divider latency cycle plus the issue-register stage, so
  // the last stage lines up with div_valid_out.
  localparam int DEPTH = DIV_LATENCY + 1;

  // -------------------------------------------------------------------------
  // Round-robin grant
  // -------------------------------------------------------------------------
  logic [ID_W-1:0]              ptr;
  logic [N_REQ-1:0]             grant;
  logic [ID_W-1:0]              grant_id;
  logic                         grant_any;
  logic [ID_W:0]                scan_sum;
  logic [ID_W-1:0]              scan_idx;

  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int off = 0; off < N_REQ; off++) begin
      // Candidate index = (ptr + off) mod N_REQ, using one extra bit so the
      // wrap works for non-power-of-two N_REQ.
      scan_sum = {1'b0, ptr} + (ID_W+1)'(off);
      if (scan_sum >= (ID_W+1)'(N_REQ)) begin
        scan_sum = scan_sum - (ID_W+1)'(N_REQ);
      end
      scan_idx = scan_sum[ID_W-1:0];
      if (!grant_any && req_valid[scan_idx]) begin
        grant_any       = 1'b1;
        grant_id        = scan_idx;
        grant[scan_idx] = 1'b1;
      end
    end
    if (reset) begin
      grant     = '0;
      grant_any = 1'b0;
    end
  end

  assign req_ready = grant;

  // -------------------------------------------------------------------------
  // Operand select for the granted requester
  // -------------------------------------------------------------------------
  logic [NUMERATOR_WIDTH-1:0]   acc_num;
  logic [DENOMINATOR_WIDTH-1:0] acc_den;
  logic                         acc_dbz;

  always_comb begin
    acc_num = '0;
    acc_den = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        acc_num = req_numerator[i*NUMERATOR_WIDTH +: NUMERATOR_WIDTH];
        acc_den = req_denominator[i*DENOMINATOR_WIDTH +: DENOMINATOR_WIDTH];
      end
    end
  end

  assign acc_dbz = (acc_den == '0);

  // -------------------------------------------------------------------------
  // Tag pipeline state and response decode
  // -------------------------------------------------------------------------
  logic [DEPTH-1:0]  tag_valid;
  logic [DEPTH-1:0]  tag_dbz;
  logic [ID_W-1:0]   tag_id [DEPTH];
  logic              last_valid;
  logic              last_dbz;
  logic [N_REQ-1:0]  last_onehot;
  logic              emit;

  assign last_valid = tag_valid[DEPTH-1];
  assign last_dbz   = tag_dbz[DEPTH-1];

  always_comb begin
    last_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (tag_id[DEPTH-1] == ID_W'(i)) begin
        last_onehot[i] = 1'b1;
      end
    end
  end

`ifdef LDIV_RR_ARBITER_SYNC_CHECK_EN
  // A dbz op never reaches the divider, so only non-dbz tags expect a result.
  logic sync_mismatch;
  assign sync_mismatch = (div_valid_out != (last_valid && !last_dbz));
  assign emit          = last_valid && !sync_mismatch;
`else
  logic unused_div_valid_out;
  assign unused_div_valid_out = div_valid_out;
  assign emit                 = last_valid;
  assign sync_err             = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Sequential state
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr             <= '0;
      div_valid       <= 1'b0;
      div_numerator   <= '0;
      div_denominator <= '0;
      tag_valid       <= '0;
      tag_dbz         <= '0;
      rsp_valid       <= '0;
      rsp_quotient    <= '0;
      rsp_remainder   <= '0;
      rsp_dbz         <= 1'b0;
`ifdef LDIV_RR_ARBITER_SYNC_CHECK_EN
      sync_err        <= 1'b0;
`endif
    end else begin
      // Pointer moves just past the winner; holds when nobody is accepted.
      if (grant_any) begin
        ptr <= (grant_id == ID_W'(N_REQ-1)) ? '0 : grant_id + 1'b1;
      end

      // Divide-by-zero ops are answered locally, so the divider operand
      // registers keep their old contents and valid_in stays low.
      div_valid <= grant_any && !acc_dbz;
      if (grant_any && !acc_dbz) begin
        div_numerator   <= acc_num;
        div_denominator <= acc_den;
      end

      // Every cycle shifts; idle cycles push an invalid tag.
      tag_valid <= {tag_valid[DEPTH-2:0], grant_any};
      tag_dbz   <= {tag_dbz[DEPTH-2:0], grant_any && acc_dbz};
      for (int s = DEPTH-1; s > 0; s--) begin
        tag_id[s] <= tag_id[s-1];
      end
      tag_id[0] <= grant_id;

      // Response: data buses only change when a response is emitted.
      rsp_valid <= emit ? last_onehot : '0;
      if (emit) begin
        if (last_dbz) begin
          rsp_quotient  <= '1;
          rsp_remainder <= '0;
          rsp_dbz       <= 1'b1;
        end else begin
          rsp_quotient  <= div_quotient;
          rsp_remainder <= div_remainder;
          rsp_dbz       <= 1'b0;
        end
      end

`ifdef LDIV_RR_ARBITER_SYNC_CHECK_EN
      if (sync_mismatch) begin
        sync_err <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ldiv_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ldiv_rr_arbiter
//
// Bench for ldiv_rr_arbiter. Contains a behavioural pipelined divider
// (fixed latency, reset together with the arbiter) and a transaction-level
// reference: the grant is found by scanning requesters from the rr pointer,
// each accepted op is queued with its expected response and due cycle, and
// every cycle the DUT outputs are compared with the head of that queue.
// ---------------------------------------------------------------------------
module tb_ldiv_rr_arbiter;

  localparam int N   = 4;
  localparam int NW  = 24;
  localparam int DW  = 20;
  localparam int QW  = 24;
  localparam int L   = 24;
  localparam int RSP_LAT = L + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*NW-1:0] req_numerator;
  logic [N*DW-1:0] req_denominator;
  logic [NW-1:0]   div_numerator;
  logic [DW-1:0]   div_denominator;
  logic            div_valid;
  logic [QW-1:0]   div_quotient;
  logic [NW-1:0]   div_remainder;
  logic            div_valid_out;
  logic [N-1:0]    rsp_valid;
  logic [QW-1:0]   rsp_quotient;
  logic [NW-1:0]   rsp_remainder;
  logic            rsp_dbz;
  logic            sync_err;
  logic            inj;

  ldiv_rr_arbiter #(
    .N_REQ(N), .NUMERATOR_WIDTH(NW), .DENOMINATOR_WIDTH(DW),
    .QUOTIENT_WIDTH(QW), .DIV_LATENCY(L)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_numerator(req_numerator), .req_denominator(req_denominator),
    .div_numerator(div_numerator), .div_denominator(div_denominator),
    .div_valid(div_valid),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .div_valid_out(div_valid_out),
    .rsp_valid(rsp_valid), .rsp_quotient(rsp_quotient),
    .rsp_remainder(rsp_remainder), .rsp_dbz(rsp_dbz),
    .sync_err(sync_err)
  );

  // ---------------- arithmetic helpers (truncating signed division) -------
  function automatic logic [QW-1:0] f_quot(input logic [NW-1:0] n, input logic [DW-1:0] d);
    longint sn, sd;
    sn = longint'($signed(n));
    sd = longint'(d);
    if (sd == 0) return '0;
    return QW'(sn / sd);
  endfunction

  function automatic logic [NW-1:0] f_rem(input logic [NW-1:0] n, input logic [DW-1:0] d);
    longint sn, sd;
    sn = longint'($signed(n));
    sd = longint'(d);
    if (sd == 0) return '0;
    return NW'(sn % sd);
  endfunction

  // ---------------- behavioural pipelined divider ----------------
  logic          dq_v [L];
  logic [QW-1:0] dq_q [L];
  logic [NW-1:0] dq_r [L];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < L; i++) dq_v[i] <= 1'b0;
    end else begin
      dq_v[0] <= div_valid;
      for (int i = 1; i < L; i++) dq_v[i] <= dq_v[i-1];
    end
    dq_q[0] <= f_quot(div_numerator, div_denominator);
    dq_r[0] <= f_rem(div_numerator, div_denominator);
    for (int i = 1; i < L; i++) begin
      dq_q[i] <= dq_q[i-1];
      dq_r[i] <= dq_r[i-1];
    end
  end

  assign div_valid_out = dq_v[L-1] | inj;
  assign div_quotient  = dq_q[L-1];
  assign div_remainder = dq_r[L-1];

  // ---------------- scoreboard / reference model ----------------
  typedef struct packed {
    int            due;
    int            id;
    logic [QW-1:0] q;
    logic [NW-1:0] r;
    logic          dbz;
  } exp_t;

  exp_t          exp_q[$];
  int            cyc;
  int            checks;
  int            errors;
  int            ptr_m;
  logic          started;
  logic          exp_dv;
  logic          exp_sync;
  logic [NW-1:0] exp_dnum;
  logic [DW-1:0] exp_dden;
  logic [QW-1:0] last_q;
  logic [NW-1:0] last_r;
  int            rsp_seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Per-cycle reference check, run at the falling edge.
  task automatic cycle_check();
    exp_t          e;
    int            g;
    int            idx;
    logic [NW-1:0] num;
    logic [DW-1:0] den;
    if (rsp_valid != '0) rsp_seen++;
    if (started) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        chk("rsp_valid", 64'(rsp_valid), 64'(1) << e.id);
        chk("rsp_quotient", 64'(rsp_quotient), 64'(e.q));
        chk("rsp_remainder", 64'(rsp_remainder), 64'(e.r));
        chk("rsp_dbz", 64'(rsp_dbz), 64'(e.dbz));
        last_q = e.q;
        last_r = e.r;
      end else begin
        chk("rsp_idle", 64'(rsp_valid), 64'(0));
        chk("rsp_q_hold", 64'(rsp_quotient), 64'(last_q));
        chk("rsp_r_hold", 64'(rsp_remainder), 64'(last_r));
      end
      chk("div_valid", 64'(div_valid), 64'(exp_dv));
      chk("div_numerator", 64'(div_numerator), 64'(exp_dnum));
      chk("div_denominator", 64'(div_denominator), 64'(exp_dden));
      chk("sync_err", 64'(sync_err), 64'(exp_sync));
    end
    if (reset) begin
      chk("req_ready_rst", 64'(req_ready), 64'(0));
      exp_q.delete();
      ptr_m    = 0;
      exp_dv   = 1'b0;
      exp_dnum = '0;
      exp_dden = '0;
      last_q   = '0;
      last_r   = '0;
      exp_sync = 1'b0;
      started  = 1'b1;
    end else begin
      g = -1;
      for (int off = 0; off < N; off++) begin
        idx = (ptr_m + off) % N;
        if (g < 0 && req_valid[idx]) g = idx;
      end
      chk("req_ready", 64'(req_ready), (g >= 0) ? (64'(1) << g) : 64'(0));
      exp_dv = 1'b0;
      if (g >= 0) begin
        num = req_numerator[g*NW +: NW];
        den = req_denominator[g*DW +: DW];
        e.due = cyc + RSP_LAT;
        e.id  = g;
        e.dbz = (den == '0);
        e.q   = e.dbz ? '1 : f_quot(num, den);
        e.r   = e.dbz ? '0 : f_rem(num, den);
        exp_q.push_back(e);
        ptr_m = (g + 1) % N;
        if (!e.dbz) begin
          exp_dv   = 1'b1;
          exp_dnum = num;
          exp_dden = den;
        end
      end
      if (inj) exp_sync = 1'b1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    cycle_check();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic set_req(input int i, input logic [NW-1:0] n, input logic [DW-1:0] d);
    req_valid[i] = 1'b1;
    req_numerator[i*NW +: NW]   = n;
    req_denominator[i*DW +: DW] = d;
  endtask

  task automatic run_until(input int target);
    for (int t = 0; t < 200 && cyc < target; t++) step();
    chk("wait_bound", 64'(cyc), 64'(target));
  endtask

  // ---------------- directed + random sequence ----------------
  int acc;
  int acc2;

  initial begin
    checks = 0; errors = 0; cyc = 0; ptr_m = 0; started = 1'b0;
    exp_dv = 1'b0; exp_sync = 1'b0; exp_dnum = '0; exp_dden = '0;
    last_q = '0; last_r = '0; rsp_seen = 0; inj = 1'b0;
    reset = 1'b1; req_valid = '0; req_numerator = '0; req_denominator = '0;

    repeat (3) step();
    reset = 1'b0;
    repeat (2) step();

    // Single op from requester 0: 100 / 7.
    set_req(0, NW'(100), DW'(7));
    acc = cyc;
    step();
    req_valid = '0;
    chk("t1_div_valid", 64'(div_valid), 64'(1));
    chk("t1_div_num", 64'(div_numerator), 64'(100));
    run_until(acc + 26);
    chk("t1_rsp_valid", 64'(rsp_valid), 64'(4'b0001));
    chk("t1_q", 64'(rsp_quotient), 64'(14));
    chk("t1_r", 64'(rsp_remainder), 64'(2));
    chk("t1_dbz", 64'(rsp_dbz), 64'(0));

    // Requester 2: -100 / 7.
    set_req(2, 24'hFFFF9C, DW'(7));
    acc = cyc;
    step();
    req_valid = '0;
    run_until(acc + 26);
    chk("t2_rsp_valid", 64'(rsp_valid), 64'(4'b0100));
    chk("t2_q", 64'(rsp_quotient), 64'(24'hFFFFF2));
    chk("t2_r", 64'(rsp_remainder), 64'(24'hFFFFFE));

    // Requester 3: most negative numerator over 1, then max denominator.
    set_req(3, 24'h800000, DW'(1));
    acc = cyc;
    step();
    set_req(3, 24'h7FFFFF, 20'hFFFFF);
    step();
    req_valid = '0;
    run_until(acc + 26);
    chk("t3_rsp_valid", 64'(rsp_valid), 64'(4'b1000));
    chk("t3_q", 64'(rsp_quotient), 64'(24'h800000));
    chk("t3_r", 64'(rsp_remainder), 64'(0));
    step();
    chk("t3b_q", 64'(rsp_quotient), 64'(8));
    chk("t3b_r", 64'(rsp_remainder), 64'(24'h7FFFFF - 8 * 24'hFFFFF));
    repeat (4) step();

    // All four requesters at once, pointer at 0: grants 0,1,2,3 back-to-back.
    for (int i = 0; i < N; i++) set_req(i, NW'(1000 + 37 * i), DW'(3 + i));
    acc = cyc;
    repeat (4) step();
    req_valid = '0;
    run_until(acc + 26);
    for (int k = 0; k < N; k++) begin
      chk("t4_rsp_order", 64'(rsp_valid), 64'(1) << k);
      step();
    end
    repeat (4) step();

    // Divide-by-zero from requester 1, followed by a normal op from 2.
    set_req(1, NW'(55), DW'(0));
    acc = cyc;
    step();
    req_valid = '0;
    set_req(2, NW'(91), DW'(10));
    acc2 = cyc;
    chk("t5_div_valid_dbz", 64'(div_valid), 64'(0));
    step();
    req_valid = '0;
    run_until(acc + 26);
    chk("t5_rsp_valid", 64'(rsp_valid), 64'(4'b0010));
    chk("t5_q", 64'(rsp_quotient), 64'(24'hFFFFFF));
    chk("t5_r", 64'(rsp_remainder), 64'(0));
    chk("t5_dbz", 64'(rsp_dbz), 64'(1));
    run_until(acc2 + 26);
    chk("t5b_rsp_valid", 64'(rsp_valid), 64'(4'b0100));
    chk("t5b_q", 64'(rsp_quotient), 64'(9));
    chk("t5b_r", 64'(rsp_remainder), 64'(1));
    repeat (3) step();

    // Reset while three ops are in flight: nothing may come back.
    for (int i = 0; i < 3; i++) begin
      req_valid = '0;
      set_req($urandom_range(0, N-1), NW'($urandom), DW'($urandom_range(1, 500)));
      step();
    end
    req_valid = '0;
    repeat (5) step();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    rsp_seen = 0;
    repeat (40) step();
    chk("t6_no_rsp", 64'(rsp_seen), 64'(0));
    chk("t6_sync_err", 64'(sync_err), 64'(0));
    req_valid = '1;
    #1;
    chk("t6_ptr_zero", 64'(req_ready), 64'(4'b0001));
    step();
    req_valid = '0;
    repeat (30) step();

    // Randomized traffic against the reference.
    for (int t = 0; t < 800; t++) begin
      req_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        req_numerator[i*NW +: NW] = NW'($urandom);
        case ($urandom_range(0, 7))
          0:       req_denominator[i*DW +: DW] = '0;
          1:       req_denominator[i*DW +: DW] = DW'(1);
          2:       req_denominator[i*DW +: DW] = DW'($urandom_range(2, 20));
          default: req_denominator[i*DW +: DW] = DW'($urandom);
        endcase
      end
      step();
    end
    req_valid = '0;
    repeat (RSP_LAT + 4) step();
    chk("drain", 64'(exp_q.size()), 64'(0));

`ifdef LDIV_RR_ARBITER_SYNC_CHECK_EN
    // Spurious divider result with no op in flight.
    inj = 1'b1;
    step();
    inj = 1'b0;
    chk("t7_sync_err_set", 64'(sync_err), 64'(1));
    chk("t7_no_rsp", 64'(rsp_valid), 64'(0));
    repeat (5) step();
    chk("t7_sync_err_sticky", 64'(sync_err), 64'(1));
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk("t7_sync_err_clear", 64'(sync_err), 64'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ldiv_rr_arbiter.md
Name: ldiv_rr_arbiter

Overview:
- Round-robin scheduler that shares one pipelined signed/unsigned long divider (fixed latency, one op per cycle, no stall) between N_REQ requesters.
- Accepts at most one request per cycle and drives the divider input bus.
- Tracks each in-flight op in a tag pipeline aligned to the divider latency, then routes the quotient/remainder back to the issuing requester.
- Handles divide-by-zero locally, without issuing the op to the divider.

Parameters:
- N_REQ, 4, number of requesters (2..16); ID_W = $clog2(N_REQ), minimum 1.
- NUMERATOR_WIDTH, 24, signed numerator width.
- DENOMINATOR_WIDTH, 20, unsigned denominator width.
- QUOTIENT_WIDTH, 24, signed quotient width.
- DIV_LATENCY, 24, cycles from divider valid_in sampled to valid_out high; must equal the divider's NUMERATOR_WIDTH.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  one-hot grant, combinational from req_valid and the rr pointer.
- req_numerator  in  N_REQ*NUMERATOR_WIDTH  flattened; requester i uses slice [i*NW +: NW].
- req_denominator  in  N_REQ*DENOMINATOR_WIDTH  flattened, same slicing scheme.
- div_numerator  out  NUMERATOR_WIDTH  registered, to divider.
- div_denominator  out  DENOMINATOR_WIDTH  registered, to divider.
- div_valid  out  1  registered, to divider valid_in.
- div_quotient  in  QUOTIENT_WIDTH  from divider.
- div_remainder  in  NUMERATOR_WIDTH  from divider.
- div_valid_out  in  1  from divider.
- rsp_valid  out  N_REQ  one-hot, one-cycle pulse; there is no backpressure.
- rsp_quotient  out  QUOTIENT_WIDTH  shared response bus.
- rsp_remainder  out  NUMERATOR_WIDTH  shared response bus.
- rsp_dbz  out  1  response was a divide-by-zero.
- sync_err  out  1  sticky: divider valid_out disagreed with the tag pipeline.

Behaviour:
- Reset:
  - Sets div_valid, rsp_valid, rsp_dbz and sync_err to 0; sets rsp_quotient and rsp_remainder to 0.
  - Sets the rr pointer to 0 and clears every tag pipeline stage valid.
  - Forces req_ready to 0 while reset is high.
- Arbitration:
  - Grant goes to the first i with req_valid[i]=1, searching from pointer p upward and wrapping modulo N_REQ.
  - req_ready[i]=1 only for the granted i; requesters must not condition req_valid on req_ready.
  - An accept occurs when req_valid[i] and req_ready[i] are both 1 on a clk edge. The pointer then becomes (i+1) mod N_REQ; with no accept the pointer holds.
  - Throughput: one accept per cycle with no bubbles; each of K continuously requesting sources gets 1/K of the accepts.
- Issue (accept in cycle k):
  - Denominator != 0: div_numerator/div_denominator are loaded and div_valid=1 in cycle k+1.
  - Denominator == 0: div_valid=0 in cycle k+1 and the divider data regs hold their previous values.
  - Either way, a tag {valid=1, id=i, dbz=(den==0)} enters stage 0 of a DIV_LATENCY+1 deep shift register in cycle k+1.
  - Cycles with no accept push an invalid tag.
- Completion:
  - The last tag stage is aligned with div_valid_out, so rsp_valid[id] pulses in cycle k+DIV_LATENCY+2.
  - Normal op: rsp_quotient/rsp_remainder are registered from div_quotient/div_remainder; rsp_dbz=0.
  - Dbz op: rsp_quotient = all-ones (−1); rsp_remainder = the numerator sign-extended is NOT required, it is 0; rsp_dbz=1.
  - When no tag is valid, rsp_valid=0 and the rsp data buses hold their previous values.
- Ordering: responses return in global accept order, so per-requester order is preserved.
- Same requester back-to-back: allowed when it is the only requester.
- Reset mid-operation: all in-flight tags are discarded and no responses are produced for ops accepted before reset. The divider must be reset in the same cycles, otherwise its stale valid_out sets sync_err.
- Width rules:
  - Numerator is passed unmodified as a two's-complement value.
  - Denominator is unsigned; zero is detected across all DENOMINATOR_WIDTH bits.

Optional Feature:
- Macro: LDIV_RR_ARBITER_SYNC_CHECK_EN.
- Defined:
  - Each cycle, compare div_valid_out against (last tag valid && !last tag dbz).
  - On mismatch, set sync_err=1; it stays set until reset.
  - On a spurious or missing divider result, suppress rsp_valid for that cycle.
- Undefined: sync_err is tied to 0, no compare logic is built, and responses are driven purely from the tag pipeline.

Test Plan:
- Only req 0: num=100, den=7, accepted in cycle 10 -> div_valid high in cycle 11; rsp_valid[0] in cycle 36 (DIV_LATENCY=24) with q=14, r=2, dbz=0.
- Req 2: num=−100, den=7 -> rsp_valid[2] with q=−14, r=−2.
- Req 0..3 all valid in the same cycle, pointer 0 -> grants 0,1,2,3 on consecutive cycles with no bubble; responses in that order on 4 consecutive cycles, each with the correct q/r.
- Req 1: den=0, num=55 -> div_valid stays 0; rsp_valid[1] in accept cycle+26 with q=−1, r=0, dbz=1; a valid op accepted the next cycle still completes correctly behind it.
- Reset asserted 5 cycles after 3 accepts, divider reset too -> no rsp_valid pulses afterward, pointer returns to 0, sync_err=0.
- With LDIV_RR_ARBITER_SYNC_CHECK_EN defined, force an extra div_valid_out pulse -> sync_err=1 the next cycle, no rsp_valid pulse, sync_err cleared only by reset.
